// File: rtl/gps_uart_pkg.sv
// Shared types and constants for the GPS NMEA UART receiver.
// GPS_UART_PARITY_EN adds the PARITY state (8E1 frames).
package gps_uart_pkg;

  localparam int B_DEF            = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef GPS_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/gps_uart_rx_if.sv
// Serial line in, received character and status pulses out.
// master = receiver side, slave = line driver / character consumer.
interface gps_uart_rx_if
  import gps_uart_pkg::*;
#(
  parameter int B = B_DEF
);

  logic         rx;
  logic [B-1:0] data;
  logic         load;
  logic         frame_error;
  logic         parity_error;

  modport master (
    input  rx,
    output data,
    output load,
    output frame_error,
    output parity_error
  );

  modport slave (
    output rx,
    input  data,
    input  load,
    input  frame_error,
    input  parity_error
  );

endinterface

// File: rtl/gps_uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous GPS serial line.
// RST_VAL sets the value both flops take on reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gps_uart_rx.sv
// UART receiver feeding GpsReceiver; 8N1 by default.
// Define GPS_UART_PARITY_EN for 8E1 frames with parity_error.
module gps_uart_rx
  import gps_uart_pkg::*;
#(
  parameter int B            = B_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clock,
  input  logic reset,
  gps_uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(B + 1);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] NLAST = NW'(B - 1);

  logic          rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NW-1:0] nbit, nbit_n;
  logic [B-1:0]  shift, shift_n;
  logic          tick;
  logic          ld_c, fe_c;
  logic          ld_q, fe_q;
  logic          load_o, fe_o;
  logic [B-1:0]  data_q;
`ifdef GPS_UART_PARITY_EN
  logic          pbad, pbad_n;
  logic          pe_c, pe_q, pe_o;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      nbit  <= '0;
      shift <= '0;
`ifdef GPS_UART_PARITY_EN
      pbad  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      nbit  <= nbit_n;
      shift <= shift_n;
`ifdef GPS_UART_PARITY_EN
      pbad  <= pbad_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    nbit_n  = nbit;
    shift_n = shift;
    ld_c    = 1'b0;
    fe_c    = 1'b0;
`ifdef GPS_UART_PARITY_EN
    pbad_n  = pbad;
    pe_c    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          nbit_n  = '0;
          state_n = rx_s ? IDLE : DATA;
`ifdef GPS_UART_PARITY_EN
          pbad_n  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[B-1:1]};
          nbit_n  = nbit + NW'(1);
          if (nbit == NLAST) begin
`ifdef GPS_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef GPS_UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          pbad_n  = (rx_s != even_par(64'(shift)));
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (!rx_s) begin
            fe_c    = 1'b1;
            state_n = WAIT_IDLE;
          end
`ifdef GPS_UART_PARITY_EN
          else if (pbad) pe_c = 1'b1;
`endif
          else ld_c = 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Two-stage pulse path: decision, then a registered output stage;
  // shift is stable here because no data sample follows STOP this soon.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_q   <= 1'b0;
      fe_q   <= 1'b0;
      load_o <= 1'b0;
      fe_o   <= 1'b0;
      data_q <= '0;
`ifdef GPS_UART_PARITY_EN
      pe_q   <= 1'b0;
      pe_o   <= 1'b0;
`endif
    end else begin
      ld_q   <= ld_c;
      fe_q   <= fe_c;
      load_o <= ld_q;
      fe_o   <= fe_q;
      if (ld_q) data_q <= shift;
`ifdef GPS_UART_PARITY_EN
      pe_q   <= pe_c;
      pe_o   <= pe_q;
`endif
    end
  end

  assign bus.data        = data_q;
  assign bus.load        = load_o;
  assign bus.frame_error = fe_o;
`ifdef GPS_UART_PARITY_EN
  assign bus.parity_error = pe_o;
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_gps_uart_rx.sv
// Randomized frame-level bench for gps_uart_rx (CLKS_PER_BIT=16).
// Honours GPS_UART_PARITY_EN for the 8E1 build.
module tb_gps_uart_rx;

  localparam int C = 16;
`ifdef GPS_UART_PARITY_EN
  localparam int NB      = 11;
  localparam int LAT_LIT = 171;
  localparam int SPC_LIT = 176;
`else
  localparam int NB      = 10;
  localparam int LAT_LIT = 155;
  localparam int SPC_LIT = 160;
`endif
  localparam int LAT = 2 + C / 2 + (NB - 1) * C + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   nprint = 0;

  ev_t        evq[$];
  logic [7:0] exp_data = 8'h00;
  int         ld_cyc[$];
  logic [7:0] ld_dat[$];
  int         fe_n = 0;
  int         pe_n = 0;

  gps_uart_rx_if #(.B(8)) bus ();

  gps_uart_rx #(.B(8), .CLKS_PER_BIT(C)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.load) begin
      ld_cyc.push_back(cyc);
      ld_dat.push_back(bus.data);
    end
    if (bus.frame_error) fe_n++;
    if (bus.parity_error) pe_n++;
  end

  // Frame-level model: each accepted frame yields one event LAT clocks
  // after its start edge; every other cycle all pulses must be low.
  always @(negedge clk) begin
    logic el, ef, ep;
    el = 1'b0;
    ef = 1'b0;
    ep = 1'b0;
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      case (evq[0].kind)
        0: begin el = 1'b1; exp_data = evq[0].d; end
        1: ef = 1'b1;
        default: ep = 1'b1;
      endcase
      void'(evq.pop_front());
    end
    vectors++;
    if (bus.load !== el || bus.frame_error !== ef ||
        bus.parity_error !== ep || bus.data !== exp_data) begin
      miscompares++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL model cyc=%0d load/fe/pe/data got %b%b%b %h want %b%b%b %h",
                 cyc, bus.load, bus.frame_error, bus.parity_error,
                 bus.data, el, ef, ep, exp_data);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge with the stop bit driven.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input bit par_bad, input int abort_bit,
                            output int t0);
    int k;
    bus.rx = 1'b0;
    t0 = cyc + 1;
    if (abort_bit < 0) begin
      k = !stop_ok ? 1 : (par_bad ? 2 : 0);
      evq.push_back('{cyc: t0 + LAT, kind: k, d: d});
    end
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      if (i == abort_bit) begin
        repeat (C / 2) @(negedge clk);
        return;
      end
      repeat (C) @(negedge clk);
    end
`ifdef GPS_UART_PARITY_EN
    bus.rx = (^d) ^ par_bad;
    repeat (C) @(negedge clk);
`endif
    bus.rx = stop_ok;
    repeat (C) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    bus.rx = 1'b1;
    evq.delete();
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, t2, n0, f0, p0;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_load", int'(bus.load), 0);
    check("rst_fe", int'(bus.frame_error), 0);
    check("rst_data", int'(bus.data), 0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rst_pe", int'(bus.parity_error), 0);
    idle(20);

    n0 = ld_cyc.size();
    send_frame(8'h24, 1'b1, 1'b0, -1, t0);
    idle(10);
    check("dollar_loads", ld_cyc.size() - n0, 1);
    check("dollar_lat", (ld_cyc.size() > n0) ? ld_cyc[n0] - t0 : -1, LAT_LIT);
    check("dollar_data", (ld_dat.size() > n0) ? int'(ld_dat[n0]) : -1, 'h24);

    n0 = ld_cyc.size();
    f0 = fe_n;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_loads", ld_cyc.size() - n0, 0);
    check("glitch_fe", fe_n - f0, 0);

    n0 = ld_cyc.size();
    f0 = fe_n;
    send_frame(8'h47, 1'b0, 1'b0, -1, t0);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    check("break_fe", fe_n - f0, 1);
    check("break_data_held", int'(bus.data), 'h24);
    idle(8);
    send_frame(8'h50, 1'b1, 1'b0, -1, t0);
    idle(10);
    check("break_fe_once", fe_n - f0, 1);
    check("after_break_data", (ld_dat.size() > n0) ? int'(ld_dat[n0]) : -1, 'h50);

    n0 = ld_cyc.size();
    send_frame(8'h24, 1'b1, 1'b0, -1, t0);
    send_frame(8'h47, 1'b1, 1'b0, -1, t1);
    send_frame(8'h50, 1'b1, 1'b0, -1, t2);
    idle(10);
    check("gp_loads", ld_cyc.size() - n0, 3);
    check("gp_d0", (ld_dat.size() > n0) ? int'(ld_dat[n0]) : -1, 'h24);
    check("gp_d1", (ld_dat.size() > n0 + 1) ? int'(ld_dat[n0+1]) : -1, 'h47);
    check("gp_d2", (ld_dat.size() > n0 + 2) ? int'(ld_dat[n0+2]) : -1, 'h50);
    check("gp_sp1", (ld_cyc.size() > n0 + 1) ? ld_cyc[n0+1] - ld_cyc[n0] : -1, SPC_LIT);
    check("gp_sp2", (ld_cyc.size() > n0 + 2) ? ld_cyc[n0+2] - ld_cyc[n0+1] : -1, SPC_LIT);

    n0 = ld_cyc.size();
    f0 = fe_n;
    p0 = pe_n;
    send_frame(8'h2A, 1'b1, 1'b0, 4, t0);
    do_reset();
    check("rst_mid_data", int'(bus.data), 0);
    idle(C);
    send_frame(8'h36, 1'b1, 1'b0, -1, t0);
    idle(10);
    check("rst_mid_loads", ld_cyc.size() - n0, 1);
    check("rst_mid_d", (ld_dat.size() > n0) ? int'(ld_dat[n0]) : -1, 'h36);
    check("rst_mid_err", (fe_n - f0) + (pe_n - p0), 0);

`ifdef GPS_UART_PARITY_EN
    n0 = ld_cyc.size();
    p0 = pe_n;
    send_frame(8'h41, 1'b1, 1'b1, -1, t0);
    idle(5);
    check("par_bad_pe", pe_n - p0, 1);
    check("par_bad_noload", ld_cyc.size() - n0, 0);
    send_frame(8'h41, 1'b1, 1'b0, -1, t0);
    idle(10);
    check("par_ok_pe", pe_n - p0, 1);
    check("par_ok_d", (ld_dat.size() > n0) ? int'(ld_dat[n0]) : -1, 'h41);
`endif

    for (int k = 0; k < 40; k++) begin
      int r;
      bit pb;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      pb = 1'b0;
`ifdef GPS_UART_PARITY_EN
      pb = ($urandom_range(0, 2) == 0);
`endif
      if (r < 15) begin
        bus.rx = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        idle(C + 2 + $urandom_range(0, 10));
      end else if (r < 30) begin
        send_frame(d, 1'b0, pb, -1, t0);
        bus.rx = 1'b0;
        repeat ($urandom_range(0, 40)) @(negedge clk);
        idle(4 + $urandom_range(0, 10));
      end else begin
        send_frame(d, 1'b1, pb, -1, t0);
        idle($urandom_range(0, 20));
      end
    end

    idle(LAT + 20);
    check("events_left", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gps_uart_rx.md
GPS_UART_RX -- requirements
Module: gps_uart_rx

Interface
REQ-001 SHALL have parameter B, default 8, data bits per character.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 5208 (50 MHz clock, 9600 baud NMEA), clocks per serial bit; legal values are even and >= 4.
REQ-003 SHALL have port clock  input  1  single rising-edge system clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line from the GPS module; idle high.
REQ-006 SHALL have port data  output  B  last correctly received character; this port feeds GpsReceiver.data.
REQ-007 SHALL have port load  output  1  one-cycle pulse marking data as a new valid character; this port feeds GpsReceiver.load.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port parity_error  output  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (flops reset to 1) to give rx_s; all decisions SHALL use rx_s only.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE, with a bit-period counter of width $clog2(CLKS_PER_BIT).
REQ-012 IDLE: SHALL move to START with counter cleared on the first cycle rx_s=0.
REQ-013 START: at counter = CLKS_PER_BIT/2-1, SHALL go to DATA if rx_s=0; otherwise it SHALL return to IDLE as a glitch, with no pulse output.
REQ-014 DATA: SHALL sample rx_s every CLKS_PER_BIT clocks, shift LSB first, and after B samples go to PARITY if enabled, else to STOP.
REQ-015 PARITY: SHALL sample one bit CLKS_PER_BIT clocks later and compare it with even parity over the B data bits, then go to STOP.
REQ-016 STOP: SHALL sample rx_s CLKS_PER_BIT clocks later.
- Sample 1 with no parity error: data <= shift register, load=1 for exactly one cycle, go to IDLE.
- Sample 1 with a parity error: parity_error=1 for one cycle, no load, go to IDLE.
- Sample 0: frame_error=1 for one cycle, no load, data unchanged, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: SHALL return to IDLE on the first cycle rx_s=1, so that a break or a stuck-low line produces no further pulses.
REQ-018 data SHALL be updated in the same cycle load is high and SHALL be held until the next load.
REQ-019 load, frame_error and parity_error SHALL be mutually exclusive and SHALL never be high on two consecutive cycles.
REQ-020 Latency with the macro off: load SHALL rise exactly 2 + CLKS_PER_BIT/2 + (B+1)*CLKS_PER_BIT + 1 clocks after the first clock edge that samples rx=0; the macro adds CLKS_PER_BIT.
REQ-021 A start edge arriving in the IDLE cycle directly after STOP SHALL be accepted, so back-to-back frames with no idle gap are received.
REQ-022 There is no backpressure: every load SHALL be issued regardless of the consumer, and the consumer SHALL accept one character per frame time.

Reset
REQ-023 On reset high, at any time including mid-frame, the block SHALL asynchronously force state=IDLE, counter=0, shift register=0, data=0, load=0, frame_error=0, parity_error=0 and synchronizer flops=1.
REQ-024 After reset release, the first clean frame SHALL be received normally, with no pulse generated by the aborted frame.

Configuration
REQ-025 Macro GPS_UART_PARITY_EN SHALL select the frame format.
- Defined: 8E1 frames; the PARITY state exists and parity_error is driven per REQ-015/016.
- Undefined: 8N1 frames; the PARITY state is not built and parity_error is constant 0.

Structure
REQ-026 The shared package gps_uart_pkg SHALL hold the state enumeration typedef, the default CLKS_PER_BIT and B constants, and an even-parity function.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter; all other logic SHALL sit in gps_uart_rx.

Verification (CLKS_PER_BIT=16, macro off unless stated)
REQ-028 Send 0x24 ('$') 8N1 -> a single load pulse with data=8'h24, exactly 155 clocks after the first clock edge sampling rx=0.
REQ-029 Drive rx low for 3 clocks, then high -> no load, no frame_error, state returns to IDLE.
REQ-030 Send 0x47 with the stop bit low, hold rx low for 40 clocks, then send 0x50 -> one frame_error, data stays at its prior value, then load with data=8'h50.
REQ-031 Send "$GP" back-to-back with no idle bits -> three loads with data 8'h24, 8'h47, 8'h50, spaced 160 clocks apart.
REQ-032 Assert reset during data bit 4 of 0x2A, release it, then send 0x36 -> no pulse for the aborted frame, then load with data=8'h36.
REQ-033 Macro defined: send 0x41 with parity bit 1 (wrong), then 0x41 with parity bit 0 -> parity_error for the first frame, then load with data=8'h41 for the second.
